// File: rtl/latchbank_sched.sv
// latchbank_sched: scheduler and write sequencer for a bank of SIZE single-bit
// latch entries. One requester wins each sequence. Its data bit is registered
// and presented on the entry's x. The entry's latch enable then opens for HOLD
// cycles and closes again.
// Optional build macro: LATCHBANK_SCHED_FIXED_PRIO_EN selects fixed-priority
// arbitration (lowest index wins) in place of round-robin.
//
// Handshake: i_req[k] is a level-sensitive request with no ready/valid pairing.
// It is sampled only on an IDLE edge. o_gnt[k] acknowledges it and stays high
// from SETUP through CLOSE. The requester learns the write is finished from the
// o_done pulse. Request or data changes made while o_busy is high have no effect.
module latchbank_sched #(
    parameter int SIZE = 8,
    parameter int HOLD = 2
) (
    input  logic            i_clk,
    input  logic            i_arst,
    input  logic [SIZE-1:0] i_req,
    input  logic [SIZE-1:0] i_data,
    output logic [SIZE-1:0] o_gnt,
    output logic [SIZE-1:0] o_en,
    output logic            o_busy,
    output logic            o_done,
    output logic [SIZE-1:0] o_a,
    output logic [1:0]      o_state
);
    localparam int PW = $clog2(SIZE);
    localparam int CW = $clog2(HOLD + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_OPEN  = 2'd2,
        ST_CLOSE = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   win_q;
    logic [PW-1:0]   win_c;
    logic            win_found;
    logic            dreg;
    logic [CW-1:0]   cnt;
    logic [SIZE-1:0] win_oh;
    int              cand;

`ifndef LATCHBANK_SCHED_FIXED_PRIO_EN
    logic [PW-1:0]   ptr;
`endif

    assign win_oh  = SIZE'(1) << win_q;
    assign o_state = state;

    // Arbitration: the first set request found from the search start, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_c     = '0;
        cand      = 0;
        for (int i = 0; i < SIZE; i++) begin
`ifdef LATCHBANK_SCHED_FIXED_PRIO_EN
            cand = i;
`else
            cand = (int'(ptr) + i) % SIZE;
`endif
            if (!win_found && i_req[PW'(cand)]) begin
                win_found = 1'b1;
                win_c     = PW'(cand);
            end
        end
    end

    // State register
    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, plus outputs decoded from registered state only
    always_comb begin
        state_nxt = state;
        o_gnt     = '0;
        o_en      = '0;
        o_busy    = 1'b0;
        o_done    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (win_found) state_nxt = ST_SETUP;
            end
            ST_SETUP: begin
                o_gnt     = win_oh;
                o_busy    = 1'b1;
                state_nxt = ST_OPEN;
            end
            ST_OPEN: begin
                o_gnt  = win_oh;
                o_en   = win_oh;
                o_busy = 1'b1;
                if (cnt == '0) state_nxt = ST_CLOSE;
            end
            ST_CLOSE: begin
                o_gnt     = win_oh;
                o_busy    = 1'b1;
                o_done    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Capture the winner and its data bit, and run the hold counter through OPEN
    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            win_q <= '0;
            dreg  <= 1'b0;
            cnt   <= '0;
        end else begin
            if (state == ST_IDLE && win_found) begin
                win_q <= win_c;
                dreg  <= i_data[win_c];
            end
            if (state == ST_SETUP) begin
                cnt <= CW'(HOLD - 1);
            end else if (state == ST_OPEN && cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

`ifndef LATCHBANK_SCHED_FIXED_PRIO_EN
    // Round-robin pointer moves just past the entry whose sequence is closing
    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            ptr <= '0;
        end else if (state == ST_CLOSE) begin
            ptr <= (win_q == PW'(SIZE - 1)) ? '0 : win_q + PW'(1);
        end
    end
`endif

    // Latch bank. Every x is fed from dreg, which only changes on an IDLE edge.
    // x is therefore stable around each enable window.
    I u_I [SIZE] ();

    genvar k;
    generate
        for (k = 0; k < SIZE; k++) begin : g_entry
            assign u_I[k].x = dreg;

            // Level latch: transparent while enabled, cleared asynchronously by reset
            always_latch begin
                if (!i_arst) begin
                    u_I[k].y <= 1'b0;
                end else if (o_en[k]) begin
                    u_I[k].y <= u_I[k].x;
                end
            end

            assign o_a[k] = u_I[k].y;
        end
    endgenerate
endmodule

// One latch entry: x is the data presented to the latch, y is the latched value.
interface I;
    logic x;
    logic y;
endinterface
